// File: rtl/iter_mul_div_unit.sv
// iter_mul_div_unit: multi-cycle MIPS32 multiply/divide unit with architectural HI/LO.
// Operands are reduced to magnitudes on accept and iterated one radix-2 step per
// clock. Multiply uses shift-add, divide uses restoring division. Signs are
// re-applied in a final fix-up cycle, which is also the only cycle that writes the
// result into HI/LO.
module iter_mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             isDiv;
    logic             negHi;
    logic             negLo;
    logic             bZero;
    // opnd: multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] opnd;
    // accHi/accLo: partial product (high/low) or remainder/quotient-dividend shifter.
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTrial;
    logic [WIDTH-1:0]   stepHi;
    logic [WIDTH-1:0]   stepLo;
    logic [2*WIDTH-1:0] prodRes;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    // Magnitude of an operand; signed ops take |v| (most-negative maps to itself,
    // which reads correctly as an unsigned magnitude).
    function automatic logic [WIDTH-1:0] magOf(input logic signed [WIDTH-1:0] v,
                                               input logic isSigned);
        logic signed [WIDTH-1:0] negV;
        negV = -v;
        return (isSigned && v[WIDTH-1]) ? $unsigned(negV) : $unsigned(v);
    endfunction

    // Conditional two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] negateW(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation of a 2*WIDTH-bit product.
    function automatic logic [2*WIDTH-1:0] negate2W(input logic [2*WIDTH-1:0] v,
                                                    input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    assign busy = (state != IDLE);

    // One radix-2 step: shift-add for multiply, shift-subtract-restore for divide.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
        divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, opnd};
        stepHi   = mulSum[WIDTH:1];
        stepLo   = {mulSum[0], accLo[WIDTH-1:1]};
        if (isDiv) begin
            // Trial is negative exactly when bit WIDTH is set; then keep the shifted remainder.
            stepHi = divTrial[WIDTH] ? {accHi[WIDTH-2:0], accLo[WIDTH-1]}
                                     : divTrial[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};
        end
    end

    // Sign fix-up of the finished magnitudes; divide-by-zero forces an all-ones quotient.
    always_comb begin
        prodRes = negate2W({accHi, accLo}, negLo);
        resHi   = prodRes[2*WIDTH-1:WIDTH];
        resLo   = prodRes[WIDTH-1:0];
        if (isDiv) begin
            // With a zero divisor the remainder is |a|, so restoring the dividend sign
            // reproduces the captured in_a exactly.
            resHi = negateW(accHi, negHi);
            resLo = bZero ? {WIDTH{1'b1}} : negateW(accLo, negLo);
        end
    end

    // Control FSM, operand capture, iteration registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            isDiv    <= 1'b0;
            negHi    <= 1'b0;
            negLo    <= 1'b0;
            bZero    <= 1'b0;
            opnd     <= '0;
            accHi    <= '0;
            accLo    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        isDiv <= op[1];
                        bZero <= (in_b == '0);
                        count <= '0;
                        accHi <= '0;
                        if (op[1]) begin
                            opnd  <= magOf(in_b, op[0]);
                            accLo <= magOf(in_a, op[0]);
                            negLo <= op[0] & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                            negHi <= op[0] & in_a[WIDTH-1];
                        end else begin
                            opnd  <= magOf(in_a, op[0]);
                            accLo <= magOf(in_b, op[0]);
                            negLo <= op[0] & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                            negHi <= op[0] & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        end
                        state <= CALC;
                    end
                end
                CALC: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) state <= FIX;
                end
                FIX: begin
                    hi       <= resHi;
                    lo       <= resLo;
                    done     <= 1'b1;
                    div_zero <= isDiv & bZero;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul_div_unit.sv
// Bench for iter_mul_div_unit: three instances (WIDTH 8, 32, 64) checked against a
// plain-arithmetic reference model, plus directed handshake and MTHI/MTLO scenarios.
module tb_iter_mul_div_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        start8, start32, start64;
    logic [1:0]  opS;
    logic [63:0] aS, bS, wdataS;
    logic        hiWe, loWe;

    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy64, done64, dz64;
    logic [63:0] hi64, lo64;

    int checks = 0;
    int errors = 0;

    iter_mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rstN), .start(start8), .op(opS),
        .in_a(aS[7:0]), .in_b(bS[7:0]), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'd0),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    iter_mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rstN), .start(start32), .op(opS),
        .in_a(aS[31:0]), .in_b(bS[31:0]), .hi_we(hiWe), .lo_we(loWe), .wdata(wdataS[31:0]),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    iter_mul_div_unit #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rstN), .start(start64), .op(opS),
        .in_a(aS), .in_b(bS), .hi_we(1'b0), .lo_we(1'b0), .wdata(64'd0),
        .busy(busy64), .done(done64), .div_zero(dz64), .hi(hi64), .lo(lo64)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] maskOf(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic busyOf(input int w);
        return (w == 8) ? busy8 : (w == 32) ? busy32 : busy64;
    endfunction
    function automatic logic doneOf(input int w);
        return (w == 8) ? done8 : (w == 32) ? done32 : done64;
    endfunction
    function automatic logic dzOf(input int w);
        return (w == 8) ? dz8 : (w == 32) ? dz32 : dz64;
    endfunction
    function automatic logic [63:0] hiOf(input int w);
        return (w == 8) ? {56'd0, hi8} : (w == 32) ? {32'd0, hi32} : hi64;
    endfunction
    function automatic logic [63:0] loOf(input int w);
        return (w == 8) ? {56'd0, lo8} : (w == 32) ? {32'd0, lo32} : lo64;
    endfunction

    task automatic setStart(input int w, input logic v);
        if (w == 8) start8 = v;
        else if (w == 32) start32 = v;
        else start64 = v;
    endtask

    // Reference: interpret operands as integers of width w and use wide arithmetic.
    task automatic refModel(input int w, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] eHi,
                            output logic [63:0] eLo, output logic eDz);
        logic [63:0]         m;
        logic [127:0]        ua, ub, full;
        logic signed [127:0] sa, sb, sq, sr, sp;
        m  = maskOf(w);
        ua = {64'd0, a & m};
        ub = {64'd0, b & m};
        sa = $signed(ua);
        sb = $signed(ub);
        if (a[w-1]) sa = sa - $signed(128'd1 << w);
        if (b[w-1]) sb = sb - $signed(128'd1 << w);
        eDz = 1'b0;
        if (op[1] == 1'b0) begin
            if (op[0]) begin
                sp   = sa * sb;
                full = $unsigned(sp);
            end else begin
                full = ua * ub;
            end
            eLo  = full[63:0] & m;
            full = full >> w;
            eHi  = full[63:0] & m;
        end else if (ub == 128'd0) begin
            eLo = m;
            eHi = a & m;
            eDz = 1'b1;
        end else if (op[0]) begin
            sq  = sa / sb;
            sr  = sa % sb;
            eLo = sq[63:0] & m;
            eHi = sr[63:0] & m;
        end else begin
            full = ua / ub;
            eLo  = full[63:0] & m;
            full = ua % ub;
            eHi  = full[63:0] & m;
        end
    endtask

    // Issue one operation on the selected instance and check latency, result and pulse shape.
    task automatic runOp(input int w, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] gotHi,
                         output logic [63:0] gotLo);
        logic [63:0] eHi, eLo, preHi, preLo;
        logic        eDz, preDz;
        int          cyc;
        refModel(w, op, a, b, eHi, eLo, eDz);
        @(negedge clk);
        preHi = hiOf(w);
        preLo = loOf(w);
        preDz = dzOf(w);
        opS = op;
        aS  = a;
        bS  = b;
        setStart(w, 1'b1);
        @(posedge clk);
        #1;
        setStart(w, 1'b0);
        opS = 2'($urandom_range(0, 3));
        aS  = {$urandom, $urandom};
        bS  = {$urandom, $urandom};
        checkVal($sformatf("busy w%0d", w), 64'(busyOf(w)), 64'd1);
        cyc = 0;
        while (!doneOf(w) && cyc < 4 * w + 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == w / 2) begin
                checkVal($sformatf("hold hi w%0d", w), hiOf(w), preHi);
                checkVal($sformatf("hold lo w%0d", w), loOf(w), preLo);
                checkVal($sformatf("hold dz w%0d", w), 64'(dzOf(w)), 64'(preDz));
            end
        end
        checkVal($sformatf("latency w%0d op%0d", w, op), 64'(cyc), 64'(w + 1));
        checkVal($sformatf("hi w%0d op%0d a=%0h b=%0h", w, op, a, b), hiOf(w), eHi);
        checkVal($sformatf("lo w%0d op%0d a=%0h b=%0h", w, op, a, b), loOf(w), eLo);
        checkVal($sformatf("div_zero w%0d op%0d", w, op), 64'(dzOf(w)), 64'(eDz));
        checkVal($sformatf("idle at done w%0d", w), 64'(busyOf(w)), 64'd0);
        gotHi = hiOf(w);
        gotLo = loOf(w);
        @(posedge clk);
        #1;
        checkVal($sformatf("done pulse w%0d", w), 64'(doneOf(w)), 64'd0);
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        int          k;
        k = int'($urandom_range(0, 7));
        case (k)
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            3: v = 64'd1 << (w - 1);
            4: v = 64'd7;
            default: v = {$urandom, $urandom};
        endcase
        return v & maskOf(w);
    endfunction

    initial begin
        logic [63:0] gH, gL, m, preHi;
        logic [1:0]  rop;
        int          cyc;
        int          widths[3];
        widths[0] = 8;
        widths[1] = 32;
        widths[2] = 64;

        rstN = 1'b0; start8 = 1'b0; start32 = 1'b0; start64 = 1'b0;
        opS = 2'd0; aS = '0; bS = '0; wdataS = '0; hiWe = 1'b0; loWe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset busy", 64'(busy32), 64'd0);
        checkVal("reset done", 64'(done32), 64'd0);
        checkVal("reset dz", 64'(dz32), 64'd0);
        checkVal("reset hi", 64'(hi32), 64'd0);
        checkVal("reset lo", 64'(lo32), 64'd0);
        checkVal("reset busy8", 64'(busy8), 64'd0);
        checkVal("reset busy64", 64'(busy64), 64'd0);
        rstN = 1'b1;

        // Known-answer cases at WIDTH=32
        runOp(32, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, gH, gL);
        checkVal("t1 hi", gH, 64'hFFFF_FFFE);
        checkVal("t1 lo", gL, 64'h0000_0001);
        runOp(32, 2'b01, 64'hFFFF_FFF9, 64'd6, gH, gL);
        checkVal("t2 mult hi", gH, 64'hFFFF_FFFF);
        checkVal("t2 mult lo", gL, 64'hFFFF_FFD6);
        runOp(32, 2'b00, 64'hFFFF_FFF9, 64'd6, gH, gL);
        checkVal("t2 multu hi", gH, 64'h0000_0005);
        checkVal("t2 multu lo", gL, 64'hFFFF_FFD6);
        runOp(32, 2'b11, 64'hFFFF_FFF9, 64'd2, gH, gL);
        checkVal("t3 div hi", gH, 64'hFFFF_FFFF);
        checkVal("t3 div lo", gL, 64'hFFFF_FFFD);
        runOp(32, 2'b10, 64'd100, 64'd7, gH, gL);
        checkVal("t3 divu hi", gH, 64'd2);
        checkVal("t3 divu lo", gL, 64'd14);
        runOp(32, 2'b11, 64'h8000_0000, 64'hFFFF_FFFF, gH, gL);
        checkVal("t3 ovf hi", gH, 64'd0);
        checkVal("t3 ovf lo", gL, 64'h8000_0000);
        runOp(32, 2'b10, 64'h1234, 64'd0, gH, gL);
        checkVal("t4 dz hi", gH, 64'h1234);
        checkVal("t4 dz lo", gL, 64'hFFFF_FFFF);
        checkVal("t4 dz flag", 64'(dz32), 64'd1);
        runOp(32, 2'b00, 64'd9, 64'd9, gH, gL);
        checkVal("t4 dz cleared", 64'(dz32), 64'd0);

        // Start and MTHI while busy are dropped
        @(negedge clk);
        opS = 2'b00; aS = 64'd3; bS = 64'd5; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        preHi = 64'(hi32);
        cyc = 0;
        repeat (9) begin @(posedge clk); #1; cyc++; end
        @(negedge clk);
        opS = 2'b10; aS = 64'd99; bS = 64'd0; start32 = 1'b1; hiWe = 1'b1; wdataS = 64'hDEAD;
        @(posedge clk);
        #1;
        cyc++;
        start32 = 1'b0; hiWe = 1'b0;
        checkVal("t5 mthi dropped", 64'(hi32), preHi);
        while (!done32 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checkVal("t5 latency", 64'(cyc), 64'd33);
        checkVal("t5 hi", 64'(hi32), 64'd0);
        checkVal("t5 lo", 64'(lo32), 64'd15);
        checkVal("t5 dz", 64'(dz32), 64'd0);
        @(negedge clk);
        loWe = 1'b1; wdataS = 64'hABCD;
        @(posedge clk);
        #1;
        loWe = 1'b0;
        checkVal("t5 mtlo lo", 64'(lo32), 64'hABCD);
        checkVal("t5 mtlo hi", 64'(hi32), 64'd0);
        @(negedge clk);
        hiWe = 1'b1; loWe = 1'b1; wdataS = 64'h1357;
        @(posedge clk);
        #1;
        hiWe = 1'b0; loWe = 1'b0;
        checkVal("mt both hi", 64'(hi32), 64'h1357);
        checkVal("mt both lo", 64'(lo32), 64'h1357);

        // Reset in the middle of a divide abandons it
        @(negedge clk);
        opS = 2'b11; aS = 64'hFFFF_FF9C; bS = 64'd7; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkVal("t6 busy", 64'(busy32), 64'd0);
        checkVal("t6 hi", 64'(hi32), 64'd0);
        checkVal("t6 lo", 64'(lo32), 64'd0);
        checkVal("t6 done", 64'(done32), 64'd0);
        runOp(32, 2'b11, 64'hFFFF_FF9C, 64'd7, gH, gL);
        checkVal("t6 rerun lo", gL, 64'hFFFF_FFF2);
        checkVal("t6 rerun hi", gH, 64'hFFFF_FFFE);

        // Back-to-back: a start in the done cycle is accepted
        @(negedge clk);
        opS = 2'b00; aS = 64'd2; bS = 64'd3; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checkVal("b2b first lat", 64'(cyc), 64'd9);
        checkVal("b2b first lo", 64'(lo8), 64'd6);
        aS = 64'd4; bS = 64'd5; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checkVal("b2b busy", 64'(busy8), 64'd1);
        cyc = 0;
        while (!done8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checkVal("b2b second lat", 64'(cyc), 64'd9);
        checkVal("b2b second lo", 64'(lo8), 64'd20);

        // Known-answer operand shapes at WIDTH=8 and WIDTH=64 against the model
        for (int i = 0; i < 3; i += 2) begin
            m = maskOf(widths[i]);
            runOp(widths[i], 2'b00, m, m, gH, gL);
            runOp(widths[i], 2'b01, m & 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, gH, gL);
            runOp(widths[i], 2'b00, m & 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, gH, gL);
            runOp(widths[i], 2'b11, m & 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, gH, gL);
            runOp(widths[i], 2'b10, 64'd100, 64'd7, gH, gL);
            runOp(widths[i], 2'b11, 64'd1 << (widths[i] - 1), m, gH, gL);
        end

        // Randomized operations on every width
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 25; n++) begin
                rop = 2'($urandom_range(0, 3));
                runOp(widths[i], rop, pick(widths[i]), pick(widths[i]), gH, gL);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
